exu_alu_ctrl: RTL and testbench
===============================

EXU_ALU_CTRL -- requirements
Module: exu_alu_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: datapath width.
REQ-002 Parameter TIMEOUT_CYC, default 16: ALU watchdog limit in cycles, used only under EXU_ALU_TIMEOUT_EN.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream (IDU) request valid.
REQ-006 in_ready  output  1  exu_alu_ctrl can accept a request.
REQ-007 in_a, in_b  input  WIDTH  operands.
REQ-008 in_sel  input  alusel_e  ALU operation.
REQ-009 in_rd  input  5  destination register index.
REQ-010 in_wen  input  1  register-write enable.
REQ-011 alu_a, alu_b  output  WIDTH  operands to ALU.
REQ-012 alu_sel  output  alusel_e  operation to ALU.
REQ-013 alu_valid  output  1  request to ALU.
REQ-014 alu_ready  input  1  ALU result valid this cycle.
REQ-015 alu_result  input  WIDTH  ALU result.
REQ-016 out_valid  output  1  downstream (WBU) result valid.
REQ-017 out_ready  input  1  downstream accepts.
REQ-018 out_result  output  WIDTH; out_rd  output  5; out_wen  output  1: result payload.
REQ-019 timeout_err  output  1  sticky watchdog flag; present only under EXU_ALU_TIMEOUT_EN.

Function
REQ-020 FSM states S_IDLE, S_ISSUE, S_WAIT, S_OUT; all outputs are Moore, decoded from state and registers only.
REQ-021 S_IDLE: in_ready=1; on in_valid, latch in_a/in_b/in_sel/in_rd/in_wen into operand registers and go to S_ISSUE.
REQ-022 S_ISSUE: alu_valid=1 for exactly this one cycle; always go to S_WAIT.
REQ-023 S_WAIT: alu_valid=0; on alu_ready=1, capture alu_result into the result register and go to S_OUT; otherwise stay.
REQ-024 alu_a/alu_b/alu_sel drive the operand registers and stay stable from S_ISSUE until leaving S_WAIT.
REQ-025 S_OUT: out_valid=1 with registered payload; on out_ready=1 go to S_IDLE; payload holds while out_ready=0.
REQ-026 in_ready=0 in every state except S_IDLE; no new request is accepted in the same cycle as an out handshake.
REQ-027 Latency with an ALU that responds one cycle after the request: accept at edge N, S_ISSUE in cycle N+1, alu_ready in cycle N+2, out_valid in cycle N+3; throughput one operation per 4 cycles.
REQ-028 alu_ready seen in S_IDLE, S_ISSUE or S_OUT is ignored.
REQ-029 out_wen forwards the latched in_wen unchanged; the block never suppresses a write except as required by REQ-033.

Reset
REQ-030 rst=1 at a clock edge forces S_IDLE from any state, including mid-S_WAIT and mid-S_OUT; any in-flight operation is dropped.
REQ-031 Reset values: in_ready=1 (S_IDLE), alu_valid=0, out_valid=0, out_result=0, out_rd=0, out_wen=0, alu_a=0, alu_b=0, alu_sel=ALU_ADD, timeout_err=0.

Configuration
REQ-032 Macro EXU_ALU_TIMEOUT_EN compiles in a cycle counter that clears on entry to S_WAIT and increments each cycle in S_WAIT.
REQ-033 With EXU_ALU_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYC without alu_ready, set timeout_err=1 (sticky until rst); go to S_OUT with out_result=32'hdeadbeef and out_wen=0.
REQ-034 Without EXU_ALU_TIMEOUT_EN: no counter, no timeout_err port, and S_WAIT waits indefinitely.

Structure
REQ-035 alusel_e and the state enum type exu_alu_state_e live in cpu_types_pkg; the 32'hdeadbeef error constant is defined there as EXU_ERR_RESULT.
REQ-036 exu_alu_ctrl is a single module with no sub-modules; it is the sole driver of ALU valid/A/B/ALUSel in the integrated CPU.

Verification
REQ-037 Accept ADD, A=5, B=7, rd=3, wen=1, out_ready=1 -> alu_valid high for exactly 1 cycle; out_valid in cycle N+3 with out_result=12, out_rd=3, out_wen=1.
REQ-038 Accept SUB, A=3, B=5, hold out_ready=0 for 5 cycles -> out_valid stays 1 with out_result=32'hFFFFFFFE stable and in_ready=0; then out_ready=1 -> S_IDLE the next cycle.
REQ-039 Back-to-back SLT (-1, 1) then SLTU (-1, 1) with in_valid held high -> results 1 then 0; second request accepted only after the first out handshake; 4-cycle spacing.
REQ-040 Assert rst during S_WAIT -> next cycle out_valid=0, in_ready=1; a later ALU ready pulse produces no output.
REQ-041 Under EXU_ALU_TIMEOUT_EN, ALU model never raises ready -> after 16 cycles in S_WAIT: timeout_err=1, out_valid=1, out_result=32'hdeadbeef, out_wen=0; timeout_err persists until rst.
REQ-042 alu_ready pulsed while in S_IDLE -> no state change, out_valid stays 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU operation select, EXU ALU controller state and error constant.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alusel_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } exu_alu_state_e;

  // Result reported when the ALU never answers.
  localparam logic [31:0] EXU_ERR_RESULT = 32'hdeadbeef;

endpackage

// File: rtl/exu_alu_ctrl_if.sv
// IDU request, ALU request/response and WBU result signals of the EXU ALU controller.
interface exu_alu_ctrl_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  alusel_e          in_sel;
  logic [4:0]       in_rd;
  logic             in_wen;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  alusel_e          alu_sel;
  logic             alu_valid;
  logic             alu_ready;
  logic [WIDTH-1:0] alu_result;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [4:0]       out_rd;
  logic             out_wen;

  // Controller side.
  modport master (
    input  in_valid, in_a, in_b, in_sel, in_rd, in_wen, alu_ready, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, alu_valid, out_valid, out_result, out_rd, out_wen
  );

  // IDU / ALU / WBU side.
  modport slave (
    output in_valid, in_a, in_b, in_sel, in_rd, in_wen, alu_ready, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, alu_valid, out_valid, out_result, out_rd, out_wen
  );
endinterface

// File: rtl/exu_alu_ctrl.sv
// EXU ALU controller: one request at a time through IDLE -> ISSUE -> WAIT -> OUT.
// Optional ALU watchdog with sticky timeout_err is compiled in by EXU_ALU_TIMEOUT_EN.
module exu_alu_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic           clk,
  input  logic           rst,
`ifdef EXU_ALU_TIMEOUT_EN
  output logic           timeout_err,
`endif
  exu_alu_ctrl_if.master bus
);

  exu_alu_state_e   r_state;
  exu_alu_state_e   w_state_d;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  alusel_e          r_sel;
  logic [4:0]       r_rd;
  logic             r_wen;
  logic [WIDTH-1:0] r_result;

`ifdef EXU_ALU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] r_cnt;
  logic            r_timeout;
  logic            w_timeout;
`endif

  always_comb begin
    w_state_d = r_state;
`ifdef EXU_ALU_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    unique case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_d = S_ISSUE;
      S_ISSUE: w_state_d = S_WAIT;
      S_WAIT: begin
        if (bus.alu_ready) begin
          w_state_d = S_OUT;
`ifdef EXU_ALU_TIMEOUT_EN
        end else if (r_cnt == CntW'(TIMEOUT_CYC - 1)) begin
          // Last allowed WAIT cycle without a response.
          w_state_d = S_OUT;
          w_timeout = 1'b1;
`endif
        end
      end
      S_OUT:   if (bus.out_ready) w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= ALU_ADD;
      r_rd     <= '0;
      r_wen    <= 1'b0;
      r_result <= '0;
`ifdef EXU_ALU_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      if (r_state == S_IDLE && bus.in_valid) begin
        r_a   <= bus.in_a;
        r_b   <= bus.in_b;
        r_sel <= bus.in_sel;
        r_rd  <= bus.in_rd;
        r_wen <= bus.in_wen;
      end
      if (r_state == S_WAIT && bus.alu_ready) r_result <= bus.alu_result;
`ifdef EXU_ALU_TIMEOUT_EN
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      if (w_timeout) begin
        r_timeout <= 1'b1;
        r_result  <= WIDTH'(EXU_ERR_RESULT);
        r_wen     <= 1'b0;
      end
`endif
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.alu_valid  = (r_state == S_ISSUE);
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.alu_sel    = r_sel;
  assign bus.out_valid  = (r_state == S_OUT);
  assign bus.out_result = r_result;
  assign bus.out_rd     = r_rd;
  assign bus.out_wen    = r_wen;

`ifdef EXU_ALU_TIMEOUT_EN
  assign timeout_err = r_timeout;
`endif

endmodule

// File: tb/tb_exu_alu_ctrl.sv
// Directed self-checking bench for exu_alu_ctrl; covers the watchdog when EXU_ALU_TIMEOUT_EN is set.
module tb_exu_alu_ctrl;
  import cpu_types_pkg::*;

  logic clk;
  logic rst;
  logic alu_auto;
  logic alu_rdy_man;
  logic model_rdy;
  logic [31:0] model_res;
  int checks;
  int failures;
`ifdef EXU_ALU_TIMEOUT_EN
  logic timeout_err;
`endif

  exu_alu_ctrl_if #(.WIDTH(32)) bus ();

  exu_alu_ctrl #(
    .WIDTH      (32),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef EXU_ALU_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input alusel_e sel);
    case (sel)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      default:  return 32'd0;
    endcase
  endfunction

  // ALU that answers one cycle after each request when enabled.
  always @(posedge clk) begin
    model_rdy <= alu_auto && bus.alu_valid;
    model_res <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);
  end

  assign bus.alu_ready  = model_rdy | alu_rdy_man;
  assign bus.alu_result = model_res;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input alusel_e sel, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic wen);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_rd    = rd;
    bus.in_wen   = wen;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks += 9;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL rst_alu_valid got=%b exp=0", bus.alu_valid); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    if (bus.out_result !== 32'd0) begin failures++; $display("FAIL rst_out_result got=%h exp=0", bus.out_result); end
    if (bus.out_rd !== 5'd0) begin failures++; $display("FAIL rst_out_rd got=%0d exp=0", bus.out_rd); end
    if (bus.out_wen !== 1'b0) begin failures++; $display("FAIL rst_out_wen got=%b exp=0", bus.out_wen); end
    if (bus.alu_a !== 32'd0) begin failures++; $display("FAIL rst_alu_a got=%h exp=0", bus.alu_a); end
    if (bus.alu_b !== 32'd0) begin failures++; $display("FAIL rst_alu_b got=%h exp=0", bus.alu_b); end
    if (bus.alu_sel !== ALU_ADD) begin failures++; $display("FAIL rst_alu_sel got=%0d exp=0", bus.alu_sel); end
`ifdef EXU_ALU_TIMEOUT_EN
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); end
`endif
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    send(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1);
    cyc();  // N+1: ISSUE
    bus.in_valid = 1'b0;
    checks += 4;
    if (bus.alu_valid !== 1'b1) begin failures++; $display("FAIL add_alu_valid_issue got=%b exp=1", bus.alu_valid); end
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL add_in_ready_issue got=%b exp=0", bus.in_ready); end
    if (bus.alu_a !== 32'd5) begin failures++; $display("FAIL add_alu_a got=%h exp=5", bus.alu_a); end
    if (bus.alu_b !== 32'd7) begin failures++; $display("FAIL add_alu_b got=%h exp=7", bus.alu_b); end
    cyc();  // N+2: WAIT
    checks += 3;
    if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL add_alu_valid_wait got=%b exp=0", bus.alu_valid); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_out_valid_early got=%b exp=0", bus.out_valid); end
    if (bus.alu_sel !== ALU_ADD) begin failures++; $display("FAIL add_alu_sel_wait got=%0d exp=0", bus.alu_sel); end
    cyc();  // N+3: OUT
    checks += 5;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_result !== 32'd12) begin failures++; $display("FAIL add_out_result got=%h exp=c", bus.out_result); end
    if (bus.out_rd !== 5'd3) begin failures++; $display("FAIL add_out_rd got=%0d exp=3", bus.out_rd); end
    if (bus.out_wen !== 1'b1) begin failures++; $display("FAIL add_out_wen got=%b exp=1", bus.out_wen); end
    if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL add_alu_valid_out got=%b exp=0", bus.alu_valid); end
    cyc();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_out_valid_after got=%b exp=0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready_after got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_out_stall();
    bus.out_ready = 1'b0;
    send(ALU_SUB, 32'd3, 32'd5, 5'd9, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    cyc();  // OUT
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid[%0d] got=%b exp=1", i, bus.out_valid); end
      if (bus.out_result !== 32'hFFFFFFFE) begin failures++; $display("FAIL stall_out_result[%0d] got=%h exp=fffffffe", i, bus.out_result); end
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, bus.in_ready); end
      if (i < 4) cyc();
    end
    bus.out_ready = 1'b1;
    cyc();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_release_out_valid got=%b exp=0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    send(ALU_SLT, 32'hFFFFFFFF, 32'd1, 5'd1, 1'b1);
    cyc();  // ISSUE of first; keep in_valid high with the second request
    send(ALU_SLTU, 32'hFFFFFFFF, 32'd1, 5'd2, 1'b1);
    checks++;
    if (bus.alu_sel !== ALU_SLT) begin failures++; $display("FAIL b2b_first_sel got=%0d exp=2", bus.alu_sel); end
    cyc();
    cyc();  // OUT of first
    checks += 4;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_out_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_result !== 32'd1) begin failures++; $display("FAIL b2b_slt_result got=%h exp=1", bus.out_result); end
    if (bus.out_rd !== 5'd1) begin failures++; $display("FAIL b2b_first_rd got=%0d exp=1", bus.out_rd); end
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_out got=%b exp=0", bus.in_ready); end
    cyc();  // IDLE: second accepted at the next edge
    checks += 2;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_in_ready got=%b exp=1", bus.in_ready); end
    if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_alu_valid got=%b exp=0", bus.alu_valid); end
    cyc();  // ISSUE of second
    bus.in_valid = 1'b0;
    checks += 2;
    if (bus.alu_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_alu_valid got=%b exp=1", bus.alu_valid); end
    if (bus.alu_sel !== ALU_SLTU) begin failures++; $display("FAIL b2b_second_sel got=%0d exp=3", bus.alu_sel); end
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_second_early got=%b exp=0", bus.out_valid); end
    cyc();  // OUT of second, four cycles after the first
    checks += 3;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_out_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_result !== 32'd0) begin failures++; $display("FAIL b2b_sltu_result got=%h exp=0", bus.out_result); end
    if (bus.out_rd !== 5'd2) begin failures++; $display("FAIL b2b_second_rd got=%0d exp=2", bus.out_rd); end
    cyc();
  endtask

  task automatic test_reset_in_wait();
    alu_auto = 1'b0;
    send(ALU_ADD, 32'd1, 32'd2, 5'd4, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    cyc();  // WAIT
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks += 3;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstw_out_valid got=%b exp=0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstw_in_ready got=%b exp=1", bus.in_ready); end
    if (bus.alu_a !== 32'd0) begin failures++; $display("FAIL rstw_alu_a got=%h exp=0", bus.alu_a); end
    alu_rdy_man = 1'b1;
    cyc();
    alu_rdy_man = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstw_late_ready_out[%0d] got=%b exp=0", i, bus.out_valid); end
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstw_late_ready_idle[%0d] got=%b exp=1", i, bus.in_ready); end
      cyc();
    end
    alu_auto = 1'b1;
  endtask

  task automatic test_idle_alu_ready();
    alu_rdy_man = 1'b1;
    cyc();
    cyc();
    alu_rdy_man = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks += 3;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL idle_rdy_out_valid[%0d] got=%b exp=0", i, bus.out_valid); end
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL idle_rdy_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      if (bus.alu_valid !== 1'b0) begin failures++; $display("FAIL idle_rdy_alu_valid[%0d] got=%b exp=0", i, bus.alu_valid); end
      cyc();
    end
  endtask

`ifdef EXU_ALU_TIMEOUT_EN
  task automatic test_timeout();
    alu_auto = 1'b0;
    bus.out_ready = 1'b0;
    send(ALU_ADD, 32'd1, 32'd1, 5'd7, 1'b1);
    cyc();  // ISSUE
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) cyc();  // 16 WAIT cycles
    checks += 2;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL to_out_valid_early got=%b exp=0", bus.out_valid); end
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_err_early got=%b exp=0", timeout_err); end
    cyc();
    checks += 4;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", timeout_err); end
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL to_out_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_result !== 32'hdeadbeef) begin failures++; $display("FAIL to_out_result got=%h exp=deadbeef", bus.out_result); end
    if (bus.out_wen !== 1'b0) begin failures++; $display("FAIL to_out_wen got=%b exp=0", bus.out_wen); end
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    checks += 2;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", timeout_err); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL to_idle got=%b exp=1", bus.in_ready); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_err_cleared got=%b exp=0", timeout_err); end
    alu_auto = 1'b1;
    cyc();
  endtask
`endif

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    alu_auto      = 1'b1;
    alu_rdy_man   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sel    = ALU_ADD;
    bus.in_rd     = '0;
    bus.in_wen    = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_add();
    test_out_stall();
    test_back_to_back();
    test_reset_in_wait();
    test_idle_alu_ready();
`ifdef EXU_ALU_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "bench timeout");
  end

endmodule
